// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble, flush and WB bypass.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Flush,
    input  logic [RW-1:0] RS,
    input  logic [RW-1:0] RT,
    input  logic [RW-1:0] RD,
    input  logic          UsesRT,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    input  logic [DW-1:0] ImmExt,
    input  logic [DW-1:0] PCPlus4,
    input  logic          RegWrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          MemtoReg,
    input  logic          ALUSrc,
    input  logic          RegDst,
    input  logic          Branch,
    input  logic [1:0]    ALUOp,
    input  logic          WB_RegWrite,
    input  logic [RW-1:0] WB_WN,
    input  logic [DW-1:0] WB_WD,
    output logic          Stall,
    output logic [RW-1:0] EX_RS,
    output logic [RW-1:0] EX_RT,
    output logic [RW-1:0] EX_RD,
    output logic [DW-1:0] EX_A,
    output logic [DW-1:0] EX_B,
    output logic [DW-1:0] EX_Imm,
    output logic [DW-1:0] EX_PCPlus4,
    output logic          EX_RegWrite,
    output logic          EX_MemRead,
    output logic          EX_MemWrite,
    output logic          EX_MemtoReg,
    output logic          EX_ALUSrc,
    output logic          EX_RegDst,
    output logic          EX_Branch,
    output logic [1:0]    EX_ALUOp,
    output logic [15:0]   StallCnt
);

    localparam logic [RW-1:0] C_REG_ZERO = '0;
    localparam logic [15:0]   C_CNT_MAX  = 16'hFFFF;

    logic          w_hz;
    logic          w_bubble;
    logic [DW-1:0] w_a_in;
    logic [DW-1:0] w_b_in;

    logic [RW-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_rd_d, ex_rd_q;
    logic [DW-1:0] ex_a_d, ex_a_q, ex_b_d, ex_b_q;
    logic [DW-1:0] ex_imm_d, ex_imm_q, ex_pc4_d, ex_pc4_q;
    logic [6:0]    ex_ctrl_d, ex_ctrl_q;
    logic [1:0]    ex_aluop_d, ex_aluop_q;
    logic [15:0]   stall_cnt_d, stall_cnt_q;

    always_comb begin
        w_hz = ex_ctrl_q[5] && (ex_rt_q != C_REG_ZERO) &&
               ((ex_rt_q == RS) || (UsesRT && (ex_rt_q == RT)));
        w_bubble = Flush || w_hz;
        Stall    = w_hz && !Flush;

        // The register file is written late in the cycle, so forward WB data.
        if (WB_RegWrite && (WB_WN != C_REG_ZERO) && (WB_WN == RS))
            w_a_in = WB_WD;
        else if (RS == C_REG_ZERO)
            w_a_in = '0;
        else
            w_a_in = RD1;

        if (WB_RegWrite && (WB_WN != C_REG_ZERO) && (WB_WN == RT))
            w_b_in = WB_WD;
        else if (RT == C_REG_ZERO)
            w_b_in = '0;
        else
            w_b_in = RD2;
    end

    always_comb begin
        ex_rs_d    = RS;
        ex_rt_d    = RT;
        ex_rd_d    = RD;
        ex_a_d     = w_a_in;
        ex_b_d     = w_b_in;
        ex_imm_d   = ImmExt;
        ex_pc4_d   = PCPlus4;
        ex_ctrl_d  = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch};
        ex_aluop_d = ALUOp;
        stall_cnt_d = stall_cnt_q;
        if (w_bubble) begin
            ex_ctrl_d  = '0;
            ex_aluop_d = '0;
        end
        // Flushed hazards are not counted: the stalled instruction is discarded.
        if (Stall && (stall_cnt_q != C_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            ex_pc4_q    <= '0;
            ex_ctrl_q   <= '0;
            ex_aluop_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_imm_q    <= ex_imm_d;
            ex_pc4_q    <= ex_pc4_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_aluop_q  <= ex_aluop_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign EX_RS       = ex_rs_q;
    assign EX_RT       = ex_rt_q;
    assign EX_RD       = ex_rd_q;
    assign EX_A        = ex_a_q;
    assign EX_B        = ex_b_q;
    assign EX_Imm      = ex_imm_q;
    assign EX_PCPlus4  = ex_pc4_q;
    assign EX_RegWrite = ex_ctrl_q[6];
    assign EX_MemRead  = ex_ctrl_q[5];
    assign EX_MemWrite = ex_ctrl_q[4];
    assign EX_MemtoReg = ex_ctrl_q[3];
    assign EX_ALUSrc   = ex_ctrl_q[2];
    assign EX_RegDst   = ex_ctrl_q[1];
    assign EX_Branch   = ex_ctrl_q[0];
    assign EX_ALUOp    = ex_aluop_q;
    assign StallCnt    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Scoreboard bench for id_ex_stage using directed vectors.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    logic        clk, rst_n, Flush, UsesRT;
    logic [4:0]  RS, RT, RD, WB_WN;
    logic [31:0] RD1, RD2, ImmExt, PCPlus4, WB_WD;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, WB_RegWrite;
    logic [1:0]  ALUOp;
    logic        Stall;
    logic [4:0]  EX_RS, EX_RT, EX_RD;
    logic [31:0] EX_A, EX_B, EX_Imm, EX_PCPlus4;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst, EX_Branch;
    logic [1:0]  EX_ALUOp;
    logic [15:0] StallCnt;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .RS(RS), .RT(RT), .RD(RD),
        .UsesRT(UsesRT), .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PCPlus4(PCPlus4),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .Branch(Branch), .ALUOp(ALUOp),
        .WB_RegWrite(WB_RegWrite), .WB_WN(WB_WN), .WB_WD(WB_WD),
        .Stall(Stall), .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_RD(EX_RD),
        .EX_A(EX_A), .EX_B(EX_B), .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_Branch(EX_Branch), .EX_ALUOp(EX_ALUOp), .StallCnt(StallCnt)
    );

    typedef struct {
        logic        stall;
        logic        chk_a;
        logic [31:0] a_hand;
        logic [31:0] a, b, imm, pc;
        logic [14:0] fld;
        logic [8:0]  ctrl;
        logic [15:0] cnt;
    } item_t;

    item_t q[$];
    event  item_ev;
    int    n_checks = 0;
    int    n_err    = 0;

    // Reference state of the stage as seen by the hazard rule.
    logic        m_mr;
    logic [4:0]  m_rt;
    logic [15:0] m_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ex_ctrl();
        return {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc,
                EX_RegDst, EX_Branch, EX_ALUOp};
    endfunction

    // Monitor: Stall is sampled mid-cycle, registered outputs just after the edge.
    initial begin
        item_t it;
        forever begin
            if (q.size() == 0) @(item_ev);
            it = q.pop_front();
            #2;
            chk("stall", {63'd0, Stall}, {63'd0, it.stall});
            @(posedge clk);
            #1;
            if (it.chk_a) chk("ex_a_hand", {32'd0, EX_A}, {32'd0, it.a_hand});
            chk("ex_a",    {32'd0, EX_A},       {32'd0, it.a});
            chk("ex_b",    {32'd0, EX_B},       {32'd0, it.b});
            chk("ex_imm",  {32'd0, EX_Imm},     {32'd0, it.imm});
            chk("ex_pc4",  {32'd0, EX_PCPlus4}, {32'd0, it.pc});
            chk("ex_fld",  {49'd0, EX_RS, EX_RT, EX_RD}, {49'd0, it.fld});
            chk("ex_ctrl", {55'd0, ex_ctrl()},  {55'd0, it.ctrl});
            chk("stallcnt", {48'd0, StallCnt},  {48'd0, it.cnt});
        end
    end

    task automatic set_nop();
        Flush = 0; UsesRT = 0; RS = 0; RT = 0; RD = 0;
        RD1 = 0; RD2 = 0; ImmExt = 0; PCPlus4 = 0;
        RegWrite = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
        ALUSrc = 0; RegDst = 0; Branch = 0; ALUOp = 0;
        WB_RegWrite = 0; WB_WN = 0; WB_WD = 0;
    endtask

    task automatic model_reset();
        m_mr = 0; m_rt = 0; m_cnt = 0;
    endtask

    // Called at a negedge with inputs already driven; pushes the expectation
    // for this cycle and advances to the next negedge.
    task automatic cycle(input logic es, input logic ca, input logic [31:0] ea);
        item_t it;
        logic  hz, bub;
        hz  = m_mr && (m_rt != 0) && ((m_rt == RS) || (UsesRT && (m_rt == RT)));
        bub = Flush || hz;
        it.stall  = es;
        it.chk_a  = ca;
        it.a_hand = ea;
        it.a = (WB_RegWrite && WB_WN != 0 && WB_WN == RS) ? WB_WD : ((RS == 0) ? 32'd0 : RD1);
        it.b = (WB_RegWrite && WB_WN != 0 && WB_WN == RT) ? WB_WD : ((RT == 0) ? 32'd0 : RD2);
        it.imm  = ImmExt;
        it.pc   = PCPlus4;
        it.fld  = {RS, RT, RD};
        it.ctrl = bub ? 9'd0 : {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp};
        if (hz && !Flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        it.cnt = m_cnt;
        m_mr = bub ? 1'b0 : MemRead;
        m_rt = RT;
        q.push_back(it);
        ->item_ev;
        @(negedge clk);
    endtask

    task automatic lw(input logic [4:0] rt);
        set_nop();
        RS = 5'd2; RT = rt; RD1 = 32'h1000; ImmExt = 32'd4; PCPlus4 = 32'h40;
        RegWrite = 1; MemRead = 1; MemtoReg = 1; ALUSrc = 1;
        cycle(1'b0, 1'b0, 32'd0);
    endtask

    task automatic add_r(input logic [4:0] rs, input logic [4:0] rt, input logic ures);
        set_nop();
        RS = rs; RT = rt; RD = 5'd9; UsesRT = ures; RD1 = 32'd11; RD2 = 32'd22;
        ImmExt = 32'hFFFF_FFF0; PCPlus4 = 32'h44; RegWrite = 1; RegDst = 1; ALUOp = 2'b10;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ctrl"}, {55'd0, ex_ctrl()}, 64'd0);
        chk({tag, "_data"}, {EX_A, EX_B}, 64'd0);
        chk({tag, "_imm_pc"}, {EX_Imm, EX_PCPlus4}, 64'd0);
        chk({tag, "_fld"}, {49'd0, EX_RS, EX_RT, EX_RD}, 64'd0);
        chk({tag, "_cnt"}, {48'd0, StallCnt}, 64'd0);
        chk({tag, "_stall"}, {63'd0, Stall}, 64'd0);
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: bench did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        model_reset();
        rst_n = 0;
        Flush = 1; UsesRT = 1; RS = 5'd7; RT = 5'd9; RD = 5'd1;
        RD1 = 32'hAAAA; RD2 = 32'hBBBB; ImmExt = 32'h5; PCPlus4 = 32'h8;
        RegWrite = 1; MemRead = 1; MemWrite = 1; MemtoReg = 1;
        ALUSrc = 1; RegDst = 1; Branch = 1; ALUOp = 2'b11;
        WB_RegWrite = 1; WB_WN = 5'd7; WB_WD = 32'hCCCC;
        #23;
        reset_checks("reset");

        @(negedge clk);
        set_nop();
        RS = 5'd3; RD1 = 32'd17; RegWrite = 1;
        rst_n = 1;
        cycle(1'b0, 1'b1, 32'd17);

        // Load-use: one bubble, then normal capture of the held instruction.
        lw(5'd5);
        add_r(5'd5, 5'd7, 1'b1);
        cycle(1'b1, 1'b1, 32'd11);
        cycle(1'b0, 1'b1, 32'd11);

        // RT only matters when the instruction actually reads it.
        lw(5'd6);
        add_r(5'd1, 5'd6, 1'b0);
        cycle(1'b0, 1'b0, 32'd0);
        lw(5'd6);
        add_r(5'd1, 5'd6, 1'b1);
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        lw(5'd0);
        add_r(5'd0, 5'd0, 1'b1);
        RD1 = 32'd55;
        cycle(1'b0, 1'b1, 32'd0);

        // WB bypass cases.
        set_nop();
        RS = 5'd8; RT = 5'd8; RD1 = 32'd1; RD2 = 32'd2;
        WB_RegWrite = 1; WB_WN = 5'd8; WB_WD = 32'd99;
        cycle(1'b0, 1'b1, 32'd99);
        RS = 5'd0; RT = 5'd3; WB_WN = 5'd0;
        cycle(1'b0, 1'b1, 32'd0);
        RS = 5'd8; WB_WN = 5'd8; WB_RegWrite = 0;
        cycle(1'b0, 1'b1, 32'd1);

        // Flush wins over a simultaneous load-use hazard.
        lw(5'd4);
        add_r(5'd4, 5'd0, 1'b1);
        Flush = 1; Branch = 1;
        cycle(1'b0, 1'b1, 32'd11);
        Flush = 0;
        cycle(1'b0, 1'b1, 32'd11);

        // Preload the counter near its ceiling, then let real stalls saturate it.
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 16'hFFFD;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            lw(5'd10);
            add_r(5'd10, 5'd3, 1'b1);
            cycle(1'b1, 1'b1, 32'd0 + 32'd11);
        end

        // Asynchronous reset between edges.
        lw(5'd12);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        reset_checks("async_reset");
        model_reset();
        @(negedge clk);
        add_r(5'd12, 5'd0, 1'b1);
        rst_n = 1;
        cycle(1'b0, 1'b1, 32'd11);

        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
